// File: rtl/ascon_ctrl_pkg.sv
// Shared definitions for the Ascon serial sequencer: FSM encoding, default widths and
// the derived-width helpers used to size the load and read phases.
package ascon_ctrl_pkg;

  localparam int K_DEF   = 128;
  localparam int L_DEF   = 40;
  localparam int Y_DEF   = 104;
  localparam int T_DEF   = 128;
  localparam int NONCE_W = 128;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CRST,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_GAP,
    ST_READ,
    ST_ABORT,
    ST_DONE
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Load length: longest of key, data, AD and the fixed-width nonce.
  function automatic int calc_max(input int k, input int y, input int l);
    return max2(max2(k, y), max2(l, NONCE_W));
  endfunction

  function automatic int calc_rd(input int y, input int t);
    return max2(y, t);
  endfunction

endpackage

// File: rtl/ascon_ctrl_shreg.sv
// MSB-first parallel-in serial-out shifter for one core input stream. Once the load
// index passes the stream width the register stops shifting, so the line holds bit 0.
module ascon_ctrl_shreg #(
  parameter int W  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          shift_i,
  input  logic [CW-1:0] idx_i,
  input  logic [W-1:0]  par_i,
  output logic          sdo_o
);

  logic [W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = par_i;
    end else if (shift_i && (idx_i < CW'(W - 1))) begin
      sr_d = {sr_q[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign sdo_o = sr_q[W-1];

endmodule

// File: rtl/ascon_serial_ctrl.sv
// Job sequencer for the bit-serial Ascon AEAD core: reset, serial load, start, wait, capture.
// Optional macro ASCON_TAG_CHECK_EN adds the expected-tag port and the decrypt tag check.
module ascon_serial_ctrl
  import ascon_ctrl_pkg::*;
#(
  parameter int K         = K_DEF,
  parameter int L         = L_DEF,
  parameter int Y         = Y_DEF,
  parameter int T         = T_DEF,
  parameter int START_CYC = 4,
  parameter int GAP_CYC   = 4,
  parameter int TIMEOUT   = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req,
  input  logic         decrypt_in,
  input  logic [K-1:0] key_in,
  input  logic [127:0] nonce_in,
  input  logic [L-1:0] ad_in,
  input  logic [Y-1:0] data_in,
`ifdef ASCON_TAG_CHECK_EN
  input  logic [T-1:0] exp_tag_in,
`endif
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [Y-1:0] data_out,
  output logic [T-1:0] tag_out,
  output logic         tag_ok,
  output logic         core_rst,
  output logic         keyxSI,
  output logic         noncexSI,
  output logic         associated_dataxSI,
  output logic         output_dataxSI,
  output logic         ascon_startxSI,
  output logic         decrypt,
  input  logic         output_dataxSO,
  input  logic         tagxSO,
  input  logic         ascon_readyxSO
);

  localparam int MAX = calc_max(K, Y, L);
  localparam int RD  = calc_rd(Y, T);
  localparam int CW  = $clog2(max2(MAX, TIMEOUT) + 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           mode_q;
  logic           err_q, err_d;
  logic [Y-1:0]   data_q, data_d;
  logic [T-1:0]   tag_q, tag_d;
  logic [RD-1:0]  rd_hit;
  logic           accept, in_load;
  logic           key_bit, nonce_bit, ad_bit, data_bit;

  assign accept  = (state_q == ST_IDLE) && req;
  assign in_load = (state_q == ST_LOAD);

  ascon_ctrl_shreg #(.W(K), .CW(CW)) u_key (
    .clk(clk), .rst(rst), .load_i(accept), .shift_i(in_load), .idx_i(cnt_q),
    .par_i(key_in), .sdo_o(key_bit));
  ascon_ctrl_shreg #(.W(NONCE_W), .CW(CW)) u_nonce (
    .clk(clk), .rst(rst), .load_i(accept), .shift_i(in_load), .idx_i(cnt_q),
    .par_i(nonce_in), .sdo_o(nonce_bit));
  ascon_ctrl_shreg #(.W(L), .CW(CW)) u_ad (
    .clk(clk), .rst(rst), .load_i(accept), .shift_i(in_load), .idx_i(cnt_q),
    .par_i(ad_in), .sdo_o(ad_bit));
  ascon_ctrl_shreg #(.W(Y), .CW(CW)) u_data (
    .clk(clk), .rst(rst), .load_i(accept), .shift_i(in_load), .idx_i(cnt_q),
    .par_i(data_in), .sdo_o(data_bit));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req) state_d = ST_CRST;
      ST_CRST:  if (cnt_q == CW'(1)) state_d = ST_LOAD;
      ST_LOAD:  if (cnt_q == CW'(MAX - 1)) state_d = ST_START;
      ST_START: if (cnt_q == CW'(START_CYC - 1)) state_d = ST_WAIT;
      ST_WAIT: begin
        if (ascon_readyxSO) begin
          state_d = ST_GAP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = ST_ABORT;
        end
      end
      ST_GAP:   if (cnt_q == CW'(GAP_CYC - 1)) state_d = ST_READ;
      ST_READ:  if (cnt_q == CW'(RD - 1)) state_d = ST_DONE;
      ST_ABORT: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Phase counter restarts on every state change and saturates instead of wrapping.
  always_comb begin
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (&cnt_q) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < RD; gi++) begin : g_rd_hit
      assign rd_hit[gi] = (state_q == ST_READ) && (cnt_q == CW'(gi));
    end
  endgenerate

`ifdef ASCON_TAG_CHECK_EN
  logic [T-1:0] exp_q;
  logic         tag_ok_q, tag_ok_d;
`endif

  always_comb begin
    err_d  = err_q;
    data_d = (data_q & ~rd_hit[Y-1:0]) | ({Y{output_dataxSO}} & rd_hit[Y-1:0]);
    tag_d  = (tag_q & ~rd_hit[T-1:0]) | ({T{tagxSO}} & rd_hit[T-1:0]);
    if (accept) err_d = 1'b0;
    if (state_q == ST_ABORT) err_d = 1'b1;
`ifdef ASCON_TAG_CHECK_EN
    tag_ok_d = accept ? 1'b0 : tag_ok_q;
    // Unverified plaintext is never released: a failed check wipes the result.
    if ((state_q == ST_READ) && (state_d == ST_DONE) && mode_q) begin
      tag_ok_d = (tag_d == exp_q);
      if (!tag_ok_d) data_d = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      if (accept) mode_q <= decrypt_in;
    end
  end

`ifdef ASCON_TAG_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q    <= '0;
      tag_ok_q <= 1'b0;
    end else begin
      tag_ok_q <= tag_ok_d;
      if (accept) exp_q <= exp_tag_in;
    end
  end
  assign tag_ok = tag_ok_q;
`else
  assign tag_ok = 1'b0;
`endif

  assign busy               = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done               = (state_q == ST_DONE);
  assign err                = err_q;
  assign data_out           = data_q;
  assign tag_out            = tag_q;
  assign core_rst           = (state_q == ST_CRST) || (state_q == ST_ABORT);
  assign decrypt            = mode_q;
  assign ascon_startxSI     = (state_q == ST_START);
  assign keyxSI             = in_load & key_bit;
  assign noncexSI           = in_load & nonce_bit;
  assign associated_dataxSI = in_load & ad_bit;
  assign output_dataxSI     = in_load & data_bit;

endmodule

// File: tb/tb_ascon_serial_ctrl.sv
// Directed bench for ascon_serial_ctrl with a stand-in serial core: the core deserialises the
// streams, XORs data with a fixed keystream matching the reference vector, and derives a tag.
module tb_ascon_serial_ctrl;

  localparam logic [127:0] KEY   = 128'h6d4f8bbf60ec05a07b201d4e5b2119ac;
  localparam logic [127:0] NONCE = 128'h05885e606e1271b8d47a74c7b297a318;
  localparam logic [39:0]  AD    = 40'h4153434f4e;
  localparam logic [103:0] PT1   = 104'h6173636f6e2d756e6963617373;
  localparam logic [103:0] CT1   = 104'h18490112f8d5867a830748390b;
  localparam logic [103:0] KS    = PT1 ^ CT1;
`ifdef ASCON_TAG_CHECK_EN
  localparam bit TAGCHK = 1'b1;
`else
  localparam bit TAGCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0;
  logic decrypt_in = 1'b0;
  logic [127:0] key_in = '0, nonce_in = '0, exp_tag = '0;
  logic [39:0]  ad_in = '0;
  logic [103:0] data_in = '0;
  logic busy, done, err, tag_ok, core_rst, decrypt;
  logic keyxSI, noncexSI, associated_dataxSI, output_dataxSI, ascon_startxSI;
  logic output_dataxSO, tagxSO;
  logic [103:0] data_out;
  logic [127:0] tag_out;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ascon_serial_ctrl #(.TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .req(req), .decrypt_in(decrypt_in),
    .key_in(key_in), .nonce_in(nonce_in), .ad_in(ad_in), .data_in(data_in),
`ifdef ASCON_TAG_CHECK_EN
    .exp_tag_in(exp_tag),
`endif
    .busy(busy), .done(done), .err(err), .data_out(data_out), .tag_out(tag_out),
    .tag_ok(tag_ok), .core_rst(core_rst), .keyxSI(keyxSI), .noncexSI(noncexSI),
    .associated_dataxSI(associated_dataxSI), .output_dataxSI(output_dataxSI),
    .ascon_startxSI(ascon_startxSI), .decrypt(decrypt),
    .output_dataxSO(output_dataxSO), .tagxSO(tagxSO), .ascon_readyxSO(m_ready));

  function automatic logic [127:0] model_tag(input logic [127:0] k, input logic [127:0] n,
                                             input logic [39:0] a, input logic [103:0] c);
    return k ^ {n[63:0], n[127:64]} ^ {c, 24'h0} ^ {88'h0, a};
  endfunction

  // Stand-in core
  logic [127:0] m_key, m_nonce, m_tag;
  logic [39:0]  m_ad;
  logic [103:0] m_din, m_dout;
  logic m_armed, m_started, m_ready;
  int m_cnt, m_lat, m_rcnt, m_idx;
  int load_bad = 0;
  bit hold_ready_low = 1'b0;

  always @(posedge clk) begin
    if (rst || core_rst) begin
      m_armed   <= !rst;
      m_cnt     <= 0;
      m_started <= 1'b0;
      m_ready   <= 1'b0;
      m_lat     <= 0;
      m_rcnt    <= 0;
    end else begin
      if (m_armed) begin
        m_key[127 - m_cnt]   <= keyxSI;
        m_nonce[127 - m_cnt] <= noncexSI;
        if (m_cnt < 104) m_din[103 - m_cnt] <= output_dataxSI;
        else if (output_dataxSI !== m_din[0]) load_bad <= load_bad + 1;
        if (m_cnt < 40) m_ad[39 - m_cnt] <= associated_dataxSI;
        else if (associated_dataxSI !== m_ad[0]) load_bad <= load_bad + 1;
        if (m_cnt == 127) m_armed <= 1'b0;
        m_cnt <= m_cnt + 1;
      end
      if (ascon_startxSI && !m_started) begin
        m_started <= 1'b1;
        m_dout    <= m_din ^ KS;
        m_tag     <= model_tag(m_key, m_nonce, m_ad, decrypt ? m_din : (m_din ^ KS));
      end
      if (m_started && !m_ready && !hold_ready_low) begin
        if (m_lat == 9) m_ready <= 1'b1;
        m_lat <= m_lat + 1;
      end
      if (m_ready) m_rcnt <= m_rcnt + 1;
    end
  end

  assign m_idx = m_rcnt - 5;
  always_comb begin
    output_dataxSO = 1'b0;
    tagxSO         = 1'b0;
    if (m_ready && m_idx >= 0) begin
      if (m_idx < 104) output_dataxSO = m_dout[m_idx];
      if (m_idx < 128) tagxSO = m_tag[m_idx];
    end
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_job(input logic dec, input logic [103:0] din, input logic [127:0] etag,
                         input int rst_at, input int p1, input int p2,
                         output int lat, output int nd);
    int cyc;
    lat = -1;
    nd  = 0;
    cyc = 0;
    @(negedge clk);
    decrypt_in = dec; key_in = KEY; nonce_in = NONCE; ad_in = AD;
    data_in = din; exp_tag = etag; req = 1'b1;
    while (cyc < 3000) begin
      @(posedge clk);
      cyc++;
      #1;
      if (done) begin
        nd++;
        if (lat < 0) lat = cyc;
      end
      if (cyc == 3) check_eq("err_clear_on_accept", {127'd0, err}, 128'd0);
      if (rst_at > 0 && cyc == rst_at + 1) begin
        check_eq("rst_busy", {127'd0, busy}, 128'd0);
        check_eq("rst_core_rst", {127'd0, core_rst}, 128'd0);
        check_eq("rst_si", {123'd0, keyxSI, noncexSI, associated_dataxSI, output_dataxSI,
                            ascon_startxSI}, 128'd0);
        check_eq("rst_data", {24'd0, data_out}, 128'd0);
        rst = 1'b0;
        break;
      end
      if (lat >= 0 && cyc >= lat + 20) break;
      @(negedge clk);
      req = (cyc == p1) || (cyc == p2);
      rst = (rst_at > 0 && cyc == rst_at);
    end
    req = 1'b0;
    $display("job dec=%0b lat=%0d dones=%0d err=%0b data=%h tag=%h tag_ok=%0b",
             dec, lat, nd, err, data_out, tag_out, tag_ok);
  endtask

  initial begin
    logic [127:0] t1;
    logic [103:0] prev_data;
    int lat, nd;
    t1 = model_tag(KEY, NONCE, AD, CT1);

    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs", {114'd0, busy, done, err, tag_ok, core_rst, decrypt, keyxSI,
             noncexSI, associated_dataxSI, output_dataxSI, ascon_startxSI, 3'd0}, 128'd0);
    check_eq("reset_data", {24'd0, data_out}, 128'd0);
    check_eq("reset_tag", tag_out, 128'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: encrypt
    run_job(1'b0, PT1, 128'd0, -1, -1, -1, lat, nd);
    check_eq("t1_dones", 128'(nd), 128'd1);
    check_eq("t1_latency", 128'(lat), 128'd275);
    check_eq("t1_err", {127'd0, err}, 128'd0);
    check_eq("t1_ct", {24'd0, data_out}, {24'd0, CT1});
    check_eq("t1_tag", tag_out, t1);
    check_eq("t1_tag_ok", {127'd0, tag_ok}, 128'd0);
    check_eq("t1_idle_busy", {127'd0, busy}, 128'd0);

    // 2: decrypt with correct tag
    run_job(1'b1, CT1, t1, -1, -1, -1, lat, nd);
    check_eq("t2_pt", {24'd0, data_out}, {24'd0, PT1});
    check_eq("t2_tag", tag_out, t1);
    check_eq("t2_tag_ok", {127'd0, tag_ok}, {127'd0, TAGCHK && (tag_out == exp_tag)});

    // 3: decrypt with a corrupted expected tag
    run_job(1'b1, CT1, t1 ^ 128'd1, -1, -1, -1, lat, nd);
    check_eq("t3_tag_ok", {127'd0, tag_ok}, 128'd0);
    check_eq("t3_data", {24'd0, data_out}, TAGCHK ? 128'd0 : {24'd0, PT1});
    prev_data = TAGCHK ? 104'd0 : PT1;

    // 4: core never ready -> timeout abort
    hold_ready_low = 1'b1;
    run_job(1'b0, PT1, 128'd0, -1, -1, -1, lat, nd);
    check_eq("t4_err", {127'd0, err}, 128'd1);
    check_eq("t4_latency", 128'(lat), 128'd200);
    check_eq("t4_dones", 128'(nd), 128'd1);
    check_eq("t4_data_kept", {24'd0, data_out}, {24'd0, prev_data});
    check_eq("t4_tag_kept", tag_out, t1);
    hold_ready_low = 1'b0;

    // 6: req pulses during LOAD and WAIT are ignored
    run_job(1'b0, PT1, 128'd0, -1, 50, 137, lat, nd);
    check_eq("t6_dones", 128'(nd), 128'd1);
    check_eq("t6_latency", 128'(lat), 128'd275);
    check_eq("t6_ct", {24'd0, data_out}, {24'd0, CT1});
    check_eq("t6_tag", tag_out, t1);

    // 5: reset during LOAD cycle 50, then a fresh encrypt
    run_job(1'b0, PT1, 128'd0, 53, -1, -1, lat, nd);
    check_eq("t5_no_done", 128'(nd), 128'd0);
    run_job(1'b0, PT1, 128'd0, -1, -1, -1, lat, nd);
    check_eq("t5_ct", {24'd0, data_out}, {24'd0, CT1});
    check_eq("t5_tag", tag_out, t1);
    check_eq("t5_latency", 128'(lat), 128'd275);

    check_eq("load_hold_bits", 128'(load_bad), 128'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
